// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

    localparam int MAX_W = 64;

    // Two's-complement negation for any width up to MAX_W; callers truncate the result.
    function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] x);
        return ~x + 1'b1;
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand / product handshake bundle for seq_multiplier.
interface seq_multiplier_if #(parameter int N = 4);

    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           is_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] P;

    modport master (
        output in_valid, A, B, is_signed, out_ready,
        input  in_ready, out_valid, P
    );

    modport slave (
        input  in_valid, A, B, is_signed, out_ready,
        output in_ready, out_valid, P
    );

endinterface

// File: rtl/seq_multiplier_rca.sv
// Parametrised ripple-carry adder with carry in and carry out.
module seq_multiplier_rca #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add N x N multiplier, one partial product per cycle, signed or unsigned
// per transaction. Signed operands are reduced to magnitudes; the sign is reapplied at the end.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_multiplier_if.slave  bus
);

    localparam int CW = $clog2(N) + 1;

    mult_state_t     state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [2*N-1:0]  p_q, p_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [N-1:0]    amag_q, amag_d;
    logic [N-1:0]    bmag_q, bmag_d;
    logic            neg_q, neg_d;

    logic [N-1:0]    a_neg, b_neg;
    logic [N-1:0]    addend, acc_sum;
    logic            acc_co;
    logic [2*N-1:0]  acc_next, p_neg;
    logic            unused_co_a, unused_co_b, unused_co_p, unused_acc_lsb;

    // Operand magnitudes: invert and add one through the carry-in.
    seq_multiplier_rca #(.N(N)) u_neg_a (
        .a(~bus.A), .b('0), .cin(1'b1), .sum(a_neg), .cout(unused_co_a)
    );
    seq_multiplier_rca #(.N(N)) u_neg_b (
        .a(~bus.B), .b('0), .cin(1'b1), .sum(b_neg), .cout(unused_co_b)
    );

    assign addend = bmag_q[0] ? amag_q : '0;

    seq_multiplier_rca #(.N(N)) u_acc (
        .a(acc_q[2*N-1:N]), .b(addend), .cin(1'b0), .sum(acc_sum), .cout(acc_co)
    );

    // Carry lands in the top bit as the whole accumulator shifts right by one.
    assign acc_next = {acc_co, acc_sum, acc_q[N-1:1]};
    assign unused_acc_lsb = acc_q[0];

    seq_multiplier_rca #(.N(2*N)) u_neg_p (
        .a(~acc_next), .b('0), .cin(1'b1), .sum(p_neg), .cout(unused_co_p)
    );

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        p_d         = p_q;
        count_d     = count_q;
        acc_d       = acc_q;
        amag_d      = amag_q;
        bmag_d      = bmag_q;
        neg_d       = neg_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    amag_d     = (bus.is_signed && bus.A[N-1]) ? a_neg : bus.A;
                    bmag_d     = (bus.is_signed && bus.B[N-1]) ? b_neg : bus.B;
                    neg_d      = bus.is_signed && (bus.A[N-1] ^ bus.B[N-1]);
                    acc_d      = '0;
                    count_d    = '0;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                acc_d   = acc_next;
                bmag_d  = bmag_q >> 1;
                count_d = count_q + 1'b1;
                if (count_q == CW'(N - 1)) begin
                    p_d         = neg_q ? p_neg : acc_next;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            amag_q      <= '0;
            bmag_q      <= '0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            p_q         <= p_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            amag_q      <= amag_d;
            bmag_q      <= bmag_d;
            neg_q       <= neg_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.P         = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomized checks of seq_multiplier at N=4 and N=8.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_multiplier_if #(.N(4)) m4 ();
    seq_multiplier_if #(.N(8)) m8 ();

    seq_multiplier #(.N(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(m4.slave));
    seq_multiplier #(.N(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(m8.slave));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid4(output int lat);
        lat = 0;
        while (!m4.out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic s, input logic [7:0] exp);
        int lat;
        m4.A = a; m4.B = b; m4.is_signed = s; m4.in_valid = 1'b1; m4.out_ready = 1'b0;
        check({tag, "_rdy"}, m4.in_ready, 1);
        step();
        m4.in_valid = 1'b0;
        wait_valid4(lat);
        check({tag, "_lat"}, lat, 4);
        check({tag, "_p"}, m4.P, exp);
        m4.out_ready = 1'b1;
        step();
        m4.out_ready = 1'b0;
        check({tag, "_ovlow"}, m4.out_valid, 0);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int lat;
        logic signed [15:0] sp;
        logic [15:0] exp;
        sp  = $signed(a) * $signed(b);
        exp = s ? sp : ({8'b0, a} * {8'b0, b});
        m8.A = a; m8.B = b; m8.is_signed = s; m8.in_valid = 1'b1;
        step();
        m8.in_valid = 1'b0;
        lat = 0;
        while (!m8.out_valid && lat < 30) begin
            step();
            lat++;
        end
        check("t6_lat", lat, 8);
        check("t6_p", m8.P, exp);
        step();
    endtask

    logic [3:0] a5 [4] = '{4'd9, 4'd15, 4'd12, 4'd6};
    logic [3:0] b5 [4] = '{4'd3, 4'd15, 4'd13, 4'd1};
    logic       s5 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] e5 [4] = '{8'h1B, 8'hE1, 8'h0C, 8'h06};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        m4.in_valid = 1'b0; m4.A = '0; m4.B = '0; m4.is_signed = 1'b0; m4.out_ready = 1'b0;
        m8.in_valid = 1'b0; m8.A = '0; m8.B = '0; m8.is_signed = 1'b0; m8.out_ready = 1'b0;
        repeat (2) step();
        check("rst_rdy4", m4.in_ready, 1);
        check("rst_ov4", m4.out_valid, 0);
        check("rst_p4", m4.P, 0);
        check("rst_rdy8", m8.in_ready, 1);
        check("rst_p8", m8.P, 0);
        rst_n = 1'b1;
        step();

        // T1 / T2
        run4("t1", 4'd15, 4'd15, 1'b0, 8'hE1);
        run4("t2a", 4'h8, 4'h8, 1'b1, 8'h40);
        run4("t2b", 4'hD, 4'h5, 1'b1, 8'hF1);
        run4("t2c", 4'h8, 4'h1, 1'b0, 8'h08);

        // T3: backpressure, with a competing request held during DONE
        m4.A = 4'd6; m4.B = 4'd7; m4.is_signed = 1'b0; m4.in_valid = 1'b1;
        step();
        m4.in_valid = 1'b0;
        wait_valid4(lat);
        check("t3_lat", lat, 4);
        check("t3_p", m4.P, 8'h2A);
        m4.A = 4'd3; m4.B = 4'd3; m4.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t3_hold_ov", m4.out_valid, 1);
            check("t3_hold_rdy", m4.in_ready, 0);
            check("t3_hold_p", m4.P, 8'h2A);
        end
        m4.in_valid = 1'b0; m4.out_ready = 1'b1;
        step();
        m4.out_ready = 1'b0;
        check("t3_ov_drop", m4.out_valid, 0);
        check("t3_rdy_back", m4.in_ready, 1);
        check("t3_p_kept", m4.P, 8'h2A);

        // T4: reset during the second CALC cycle
        m4.A = 4'd7; m4.B = 4'd7; m4.in_valid = 1'b1;
        step();
        m4.in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t4_rdy", m4.in_ready, 1);
        check("t4_ov", m4.out_valid, 0);
        check("t4_p", m4.P, 0);
        repeat (6) step();
        check("t4_no_result", m4.out_valid, 0);
        run4("t4", 4'd3, 4'd5, 1'b0, 8'd15);

        // T5: in_valid and out_ready tied high
        m4.out_ready = 1'b1;
        m4.A = a5[0]; m4.B = b5[0]; m4.is_signed = s5[0]; m4.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_rdy", m4.in_ready, 1);
            step();
            if (i < 3) begin
                m4.A = a5[i+1]; m4.B = b5[i+1]; m4.is_signed = s5[i+1];
            end else begin
                m4.in_valid = 1'b0;
            end
            wait_valid4(lat);
            check("t5_lat", lat, 4);
            check("t5_p", m4.P, e5[i]);
            step();
            check("t5_ovlow", m4.out_valid, 0);
        end
        m4.out_ready = 1'b0;

        // T6: N=8 edge cases then random vectors in both modes
        m8.out_ready = 1'b1;
        run8(8'h80, 8'h80, 1'b1);
        run8(8'h80, 8'h80, 1'b0);
        run8(8'h80, 8'h00, 1'b1);
        run8(8'hFF, 8'h00, 1'b0);
        run8(8'h80, 8'h01, 1'b1);
        run8(8'h7F, 8'h80, 1'b1);
        run8(8'hFF, 8'hFF, 1'b1);
        run8(8'hFF, 8'hFF, 1'b0);
        run8(8'h00, 8'h80, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
